cordic_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency hyperbolic CORDIC pipeline (sigmoid/tanh/exp activation unit) between NUM_REQ requesters in the VAE datapath. It accepts operands on per-requester valid/ready ports and issues at most one operand per cycle into the free-running CORDIC. A tag delay line tracks the requester ID of every operand in flight. Results go into a result FIFO drained with a valid/ready handshake; credit-based issue control guarantees that FIFO never overflows, so the stall-free CORDIC pipeline never needs back-pressure.

---
 rtl/cordic_sched.sv | 140 ++++++++++++++
 tb/tb_cordic_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Round-robin scheduler feeding NUM_REQ operand streams into one free-running CORDIC pipeline.
// A tag delay line follows each operand; a credit check keeps the result FIFO from overflowing.
module cordic_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int CORDIC_LAT = 20,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         cor_din,
  input  logic [DATA_WIDTH-1:0]         cor_dout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy,
  output logic                          ovf_err
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(CORDIC_LAT + 2);
  localparam int SW = $clog2(FIFO_DEPTH + CORDIC_LAT + 2);

  logic [ID_W-1:0]       last_gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  gnt_found;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  issue_ok;
  logic                  hs;
  int                    best_dist;
  int                    cand_dist;
  logic                  take;

  logic [CORDIC_LAT:0]   tag_v;
  logic [ID_W-1:0]       tag_id [0:CORDIC_LAT];
  logic [IW-1:0]         inflight_cnt;

  logic [DATA_WIDTH-1:0] mem_data [0:FIFO_DEPTH-1];
  logic [ID_W-1:0]       mem_id   [0:FIFO_DEPTH-1];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: the valid requester at the smallest rotational distance after last_gnt wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    best_dist = NUM_REQ;
    cand_dist = 0;
    take      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_dist = (i + NUM_REQ - int'(last_gnt) - 1) % NUM_REQ;
      take      = req_valid[i] && (cand_dist < best_dist);
      best_dist = take ? cand_dist : best_dist;
      gnt_id    = take ? ID_W'(i) : gnt_id;
      gnt_found = gnt_found | take;
    end
  end

  // Operand mux and grant generation; the credit check uses registered counts only.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_data = (ID_W'(i) == gnt_id) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : gnt_data;
    end
    issue_ok  = (SW'(inflight_cnt) + SW'(fifo_cnt)) < SW'(FIFO_DEPTH);
    hs        = issue_ok & gnt_found & ~rst;
    req_ready = hs ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  end

  // Issue register, tag valids and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cor_din  <= '0;
      tag_v    <= '0;
      last_gnt <= ID_W'(NUM_REQ - 1);
    end else begin
      cor_din  <= hs ? gnt_data : '0;
      tag_v    <= {tag_v[CORDIC_LAT-1:0], hs};
      last_gnt <= hs ? gnt_id : last_gnt;
    end
  end

  // Tag ids are only meaningful alongside a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int s = 1; s <= CORDIC_LAT; s++) begin
      tag_id[s] <= tag_id[s-1];
    end
  end

  assign push  = tag_v[CORDIC_LAT];
  assign pop   = rsp_valid & rsp_ready;
  assign full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign wr_en = push & ~full;

  // Occupancy counters, FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ovf_err      <= 1'b0;
    end else begin
      inflight_cnt <= inflight_cnt + IW'(hs) - IW'(push);
      fifo_cnt     <= fifo_cnt + CW'(wr_en) - CW'(pop);
      wr_ptr       <= wr_en ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr       <= pop ? ptr_inc(rd_ptr) : rd_ptr;
      ovf_err      <= ovf_err | (push & full);
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= cor_dout;
      mem_id[wr_ptr]   <= tag_id[CORDIC_LAT];
    end
  end

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;
  assign busy      = (inflight_cnt != '0) | rsp_valid;

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized scoreboard bench for cordic_sched with a delay-line CORDIC stub (result = operand + 1).
module tb_cordic_sched;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int CORDIC_LAT = 20;
  localparam int FIFO_DEPTH = 32;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         cor_din;
  logic [DATA_WIDTH-1:0]         cor_dout;
  logic                          rsp_valid;
  logic                          rsp_ready = 1'b1;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]               rsp_id;
  logic                          busy;
  logic                          ovf_err;

  cordic_sched #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
    .CORDIC_LAT(CORDIC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cor_din(cor_din), .cor_dout(cor_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] dly [0:CORDIC_LAT-1];
  always @(posedge clk) begin
    dly[0] <= cor_din;
    for (int i = 1; i < CORDIC_LAT; i++) dly[i] <= dly[i-1];
  end
  assign cor_dout = dly[CORDIC_LAT-1] + 32'd1;

  int   cyc = 0;
  logic armed = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) armed <= 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    int                    id;
    int                    due;
  } exp_t;

  exp_t                  exp_q[$];
  int                    dut_gnts[$];
  int                    issued = 0;
  int                    popped = 0;
  int                    last_m = NUM_REQ - 1;
  logic [DATA_WIDTH-1:0] exp_din = '0;
  logic                  hold_v = 1'b0;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [ID_W-1:0]       hold_id;

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (((v >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  // Reference model and monitor: outstanding = issued - popped is the credit in use.
  initial forever begin
    int                    win;
    logic [NUM_REQ-1:0]    exp_rdy;
    logic                  exp_v;
    logic [DATA_WIDTH-1:0] d;
    exp_t                  e;
    @(negedge clk);
    if (armed) begin
      win = -1;
      exp_rdy = '0;
      if (!rst && (issued - popped) < FIFO_DEPTH) begin
        win = pick(req_valid, last_m);
        if (win >= 0) exp_rdy = 4'b0001 << win;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("cor_din", cor_din, exp_din);
      chk("busy", busy, (issued != popped));
      chk("ovf_err", ovf_err, 1'b0);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      chk("rsp_valid", rsp_valid, exp_v);
      if (hold_v) begin
        chk("hold_data", rsp_data, hold_data);
        chk("hold_id", rsp_id, hold_id);
      end
      if (!rst) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (req_valid[i] && req_ready[i]) dut_gnts.push_back(i);
      end
      if (rst) begin
        issued = 0;
        popped = 0;
        last_m = NUM_REQ - 1;
        exp_din = '0;
        exp_q.delete();
        hold_v = 1'b0;
      end else begin
        hold_v = rsp_valid && !rsp_ready;
        hold_data = rsp_data;
        hold_id = rsp_id;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_extra", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_id", rsp_id, e.id);
            popped++;
          end
        end
        exp_din = '0;
        if (win >= 0) begin
          d = DATA_WIDTH'(req_data >> (win * DATA_WIDTH));
          exp_din = d;
          exp_q.push_back('{d + 32'd1, win, cyc + CORDIC_LAT + 2});
          issued++;
          last_m = win;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 1'b0);
    step();
  endtask

  initial begin
    int t0;
    int n;
    int pat [4] = '{1, 0, 0, 1};
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Fairness: all requesters valid for 12 cycles.
    dut_gnts.delete();
    for (int k = 0; k < 12; k++) begin
      req_valid = 4'b1111;
      rand_data();
      step();
    end
    req_valid = '0;
    chk("fair_count", dut_gnts.size(), 12);
    for (int k = 0; k < 12 && k < dut_gnts.size(); k++) chk("fair_order", dut_gnts[k], k % NUM_REQ);
    drain(100);

    // Single operation latency from requester 2.
    req_valid = 4'b0100;
    req_data = '0;
    req_data[2*DATA_WIDTH +: DATA_WIDTH] = 32'h0001_0000;
    t0 = cyc;
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("single_lat", cyc - t0, 22);
    chk("single_data", rsp_data, 32'h0001_0001);
    chk("single_id", rsp_id, 2'd2);
    step();
    @(negedge clk);
    chk("single_busy", busy, 1'b0);
    step();

    // Back-pressure: consumer stalled, continuous requests.
    rsp_ready = 1'b0;
    dut_gnts.delete();
    for (int k = 0; k < 45; k++) begin
      req_valid = 4'b1111;
      rand_data();
      step();
    end
    chk("bp_grants", dut_gnts.size(), FIFO_DEPTH);
    chk("bp_blocked", req_ready, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      rsp_ready = pat[k][0];
      rand_data();
      step();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      step();
    end
    req_valid = '0;
    drain(200);

    // Reset mid-flight: 5 ops, reset at relative cycle 10.
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0001 << (k % NUM_REQ);
      rand_data();
      step();
    end
    req_valid = '0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    rand_data();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_first", req_ready, 4'b0001);
    step();
    req_valid = '0;
    drain(100);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      req_valid = NUM_REQ'($urandom);
      rand_data();
      rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain(300);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
